// File: rtl/masked_keccak_f200_round.sv
// Two-share Keccak-f[200] round core: per-share theta/rho/pi, 40 two-share chi
// row cells, iota on share 1, and a start/busy/done round sequencer.

module masked_chi_row_2s (
  input  logic       clk_i,
  input  logic [4:0] in1_i,
  input  logic [4:0] in2_i,
  output logic [4:0] out1_o,
  output logic [4:0] out2_o
);
  logic [4:0] a1, a2;
  logic [4:0] t11_d, t12_d, t21_d, t22_d;
  logic [4:0] t11_q, t12_q, t21_q, t22_q;

  for (genvar x = 0; x < 5; x++) begin : g_x
    localparam int X1 = (x + 1) % 5;
    localparam int X2 = (x + 2) % 5;
    assign a1[x] = in1_i[4-x];
    assign a2[x] = in2_i[4-x];
    // cross-share products are registered before being folded into a domain
    assign t11_d[x] = a1[x] ^ (~a1[X1] & a1[X2]);
    assign t12_d[x] = ~a1[X1] & a2[X2];
    assign t21_d[x] = a2[X1] & a1[X2];
    assign t22_d[x] = a2[x] ^ (a2[X1] & a2[X2]);
    assign out1_o[4-x] = t11_q[x] ^ t12_q[x];
    assign out2_o[4-x] = t21_q[x] ^ t22_q[x];
  end

  always_ff @(posedge clk_i) begin
    t11_q <= t11_d;
    t12_q <= t12_d;
    t21_q <= t21_d;
    t22_q <= t22_d;
  end
endmodule

module masked_keccak_f200_round #(
  parameter int NUM_ROUNDS = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] state_in_s1,
  input  logic [199:0] state_in_s2,
  output logic         busy,
  output logic         done,
  output logic [199:0] state_out_s1,
  output logic [199:0] state_out_s2
);
  localparam int NUM_LANES = 25;
  localparam int LANE_W    = 8;
  localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);
  // rho offsets mod 8, element index x+5y
  localparam logic [NUM_LANES-1:0][2:0] RHO = {
    3'd6, 3'd0, 3'd5, 3'd2, 3'd2,
    3'd0, 3'd5, 3'd7, 3'd5, 3'd1,
    3'd7, 3'd1, 3'd3, 3'd2, 3'd3,
    3'd4, 3'd7, 3'd6, 3'd4, 3'd4,
    3'd3, 3'd4, 3'd6, 3'd1, 3'd0};

  typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_e;

  state_e       state_q, state_d;
  logic [4:0]   round_q, round_d;
  logic [199:0] s1_q, s1_d, s2_q, s2_d;
  logic [199:0] b1, b2, chi1, chi2;

  function automatic logic [199:0] lin_layer(input logic [199:0] a);
    logic [4:0][LANE_W-1:0] c, d;
    logic [LANE_W-1:0] ln, rt;
    logic [2:0] zi;
    logic [199:0] b;
    int dst;
    c = '0;
    b = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        c[x] = c[x] ^ a[LANE_W*(x+5*y) +: LANE_W];
    for (int x = 0; x < 5; x++)
      d[x] = c[(x+4)%5] ^ {c[(x+1)%5][6:0], c[(x+1)%5][7]};
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        ln = a[LANE_W*(x+5*y) +: LANE_W] ^ d[x];
        for (int z = 0; z < LANE_W; z++) begin
          zi = 3'(z) - RHO[x+5*y];
          rt[z] = ln[zi];
        end
        dst = y + 5*((2*x + 3*y) % 5);
        b[LANE_W*dst +: LANE_W] = rt;
      end
    return b;
  endfunction

  function automatic logic [7:0] rc(input logic [4:0] r);
    case (r)
      5'd0:  rc = 8'h01;  5'd1:  rc = 8'h82;  5'd2:  rc = 8'h8A;
      5'd3:  rc = 8'h00;  5'd4:  rc = 8'h8B;  5'd5:  rc = 8'h01;
      5'd6:  rc = 8'h81;  5'd7:  rc = 8'h09;  5'd8:  rc = 8'h8A;
      5'd9:  rc = 8'h88;  5'd10: rc = 8'h09;  5'd11: rc = 8'h0A;
      5'd12: rc = 8'h8B;  5'd13: rc = 8'h8B;  5'd14: rc = 8'h89;
      5'd15: rc = 8'h03;  5'd16: rc = 8'h02;  5'd17: rc = 8'h80;
      default: rc = 8'h00;
    endcase
  endfunction

  // each share goes through the linear layer on its own
  assign b1 = lin_layer(s1_q);
  assign b2 = lin_layer(s2_q);

  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar z = 0; z < LANE_W; z++) begin : g_z
      logic [4:0] r1, r2, o1, o2;
      for (genvar x = 0; x < 5; x++) begin : g_x
        assign r1[4-x] = b1[LANE_W*(x+5*y)+z];
        assign r2[4-x] = b2[LANE_W*(x+5*y)+z];
        assign chi1[LANE_W*(x+5*y)+z] = o1[4-x];
        assign chi2[LANE_W*(x+5*y)+z] = o2[4-x];
      end
      masked_chi_row_2s u_chi (
        .clk_i (clk),
        .in1_i (r1),
        .in2_i (r2),
        .out1_o(o1),
        .out2_o(o2)
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PH_A;
      PH_A:    state_d = PH_B;
      PH_B:    state_d = (round_q == LAST) ? DONE : PH_A;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == PH_A) || (state_q == PH_B);
    done = (state_q == DONE);
  end

  // chi registers are only read in PH_B, right after PH_A filled them
  always_comb begin
    s1_d    = s1_q;
    s2_d    = s2_q;
    round_d = round_q;
    case (state_q)
      IDLE: if (start) begin
        s1_d    = state_in_s1;
        s2_d    = state_in_s2;
        round_d = '0;
      end
      PH_B: begin
        s1_d = chi1 ^ {192'b0, rc(round_q)};
        s2_d = chi2;
        if (round_q != LAST) round_d = round_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      round_q <= round_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign state_out_s1 = s1_q;
  assign state_out_s2 = s2_q;
endmodule
